// File: rtl/cpu_arbiter_pkg.sv
// ============================================================================
// Module      : cpu_arbiter_pkg
// Description : Shared types and default constants for the CPU arbiter.
//               - slot_state_e : output slot state (EMPTY / FULL)
//               - CPU_ARB_N_CPU, CPU_ARB_DATA_W : default parameter values
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_arbiter_pkg;

    localparam int CPU_ARB_N_CPU  = 4;
    localparam int CPU_ARB_DATA_W = 64;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage : cpu_arbiter_pkg

`default_nettype wire

// File: rtl/cpu_arbiter_rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin select. The search starts at
//               (last_grant_i + 1) mod N and wraps, so the most recent
//               winner has the lowest priority.
// Ports       : req_i        [N]     request vector
//               last_grant_i [IDX_W] index of the previous winner
//               grant_o      [N]     one-hot grant (zero when no request)
//               grant_idx_o  [IDX_W] index of the granted requester
//               any_o        [1]     at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
    import cpu_arbiter_pkg::*;
#(
    parameter int N     = CPU_ARB_N_CPU,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    always_comb begin
        int  idx;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        // Offsets 1..N visit every requester once, ending at last_grant itself.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant_i) + k) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
            end
        end
        any_o = found;
    end

endmodule : rr_picker

`default_nettype wire

// File: rtl/cpu_arbiter.sv
// ============================================================================
// Module      : cpu_arbiter
// Description : Round-robin arbiter funnelling N_CPU valid/ready sources into
//               one registered output slot (1 transfer/cycle sustained).
// Ports       : clk, rst             clock, async active-high reset
//               s_vld/s_data/s_rdy   per-CPU source handshake and payload
//               s_done               per-CPU transactions-done level
//               m_vld/m_data/m_src   sink side payload and owning CPU index
//               m_rdy                sink ready
//               all_done             all CPUs done and slot empty (registered)
//               xfer_count           accepted-transfer counter
// Config      : CPU_ARBITER_STATS_EN - when defined, xfer_count counts
//               accepted transfers (wraps at 2^32); otherwise tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_arbiter
    import cpu_arbiter_pkg::*;
#(
    parameter int N_CPU  = CPU_ARB_N_CPU,
    parameter int DATA_W = CPU_ARB_DATA_W,
    parameter int IDX_W  = $clog2(N_CPU)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CPU-1:0]        s_vld,
    input  logic [N_CPU*DATA_W-1:0] s_data,
    input  logic [N_CPU-1:0]        s_done,
    output logic [N_CPU-1:0]        s_rdy,
    output logic                    m_vld,
    output logic [DATA_W-1:0]       m_data,
    output logic [IDX_W-1:0]        m_src,
    input  logic                    m_rdy,
    output logic                    all_done,
    output logic [31:0]             xfer_count
);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] m_data_q;
    logic [IDX_W-1:0]  m_src_q;
    logic [IDX_W-1:0]  last_grant_q;
    logic              all_done_q;

    logic [N_CPU-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              slot_free;
    logic              accept;

    rr_picker #(
        .N     (N_CPU),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req_i        (s_vld),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_grant),
        .grant_idx_o  (pick_idx),
        .any_o        (pick_any)
    );

    // A FULL slot that drains this cycle can accept in the same cycle.
    assign slot_free = (state_q == EMPTY) || m_rdy;
    // Grants are suppressed while reset is asserted.
    assign accept    = slot_free && pick_any && !rst;
    assign s_rdy     = accept ? pick_grant : '0;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = FULL;
        end else if ((state_q == FULL) && m_rdy) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            m_data_q     <= '0;
            m_src_q      <= '0;
            last_grant_q <= IDX_W'(N_CPU - 1);
            all_done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                m_data_q     <= s_data[int'(pick_idx)*DATA_W +: DATA_W];
                m_src_q      <= pick_idx;
                last_grant_q <= pick_idx;
            end
            // Based on the next state so a just-accepted transfer clears it.
            all_done_q <= (&s_done) && (state_d == EMPTY);
        end
    end

    assign m_vld    = (state_q == FULL);
    assign m_data   = m_data_q;
    assign m_src    = m_src_q;
    assign all_done = all_done_q;

`ifdef CPU_ARBITER_STATS_EN
    logic [31:0] xfer_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_q <= '0;
        end else if (accept) begin
            xfer_count_q <= xfer_count_q + 32'd1;
        end
    end

    assign xfer_count = xfer_count_q;
`else
    assign xfer_count = 32'd0;
`endif

endmodule : cpu_arbiter

`default_nettype wire

// File: tb/tb_cpu_arbiter.sv
// ============================================================================
// Module      : tb_cpu_arbiter
// Description : Directed self-checking bench for cpu_arbiter (N_CPU=4,
//               DATA_W=64). Inputs change on the falling edge; combinational
//               s_rdy is sampled 1ns after that, registered outputs 1ns after
//               the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int TRANSACTION_NB = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_vld;
    logic [N*DW-1:0] s_data;
    logic [N-1:0]    s_done;
    logic [N-1:0]    s_rdy;
    logic            m_vld;
    logic [DW-1:0]   m_data;
    logic [1:0]      m_src;
    logic            m_rdy;
    logic            all_done;
    logic [31:0]     xfer_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_arbiter #(.N_CPU(N), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_vld      (s_vld),
        .s_data     (s_data),
        .s_done     (s_done),
        .s_rdy      (s_rdy),
        .m_vld      (m_vld),
        .m_data     (m_data),
        .m_src      (m_src),
        .m_rdy      (m_rdy),
        .all_done   (all_done),
        .xfer_count (xfer_count)
    );

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        s_vld  = 4'hF;
        s_data = '0;
        s_done = '0;
        m_rdy  = 1'b1;
        at_neg();
        checks++; if (s_rdy !== 4'h0) begin failures++; $display("FAIL reset_s_rdy got=%h exp=0", s_rdy); end
        checks++; if (m_vld !== 1'b0) begin failures++; $display("FAIL reset_m_vld got=%b exp=0", m_vld); end
        checks++; if (m_data !== 64'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        checks++; if (m_src !== 2'd0) begin failures++; $display("FAIL reset_m_src got=%0d exp=0", m_src); end
        checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL reset_all_done got=%b exp=0", all_done); end
        checks++; if (xfer_count !== 32'd0) begin failures++; $display("FAIL reset_xfer got=%0d exp=0", xfer_count); end
        s_vld = 4'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        s_vld = 4'b0100;
        s_data[2*DW +: DW] = 64'h0123456789ABCDEF;
        m_rdy = 1'b1;
        #1;
        checks++; if (s_rdy !== 4'b0100) begin failures++; $display("FAIL single_s_rdy got=%b exp=0100", s_rdy); end
        at_pos();
        checks++; if (m_vld !== 1'b1) begin failures++; $display("FAIL single_m_vld got=%b exp=1", m_vld); end
        checks++; if (m_data !== 64'h0123456789ABCDEF) begin failures++; $display("FAIL single_m_data got=%h exp=0123456789abcdef", m_data); end
        checks++; if (m_src !== 2'd2) begin failures++; $display("FAIL single_m_src got=%0d exp=2", m_src); end
        @(negedge clk);
        s_vld = 4'b0000;
        #1;
        checks++; if (s_rdy !== 4'b0000) begin failures++; $display("FAIL single_s_rdy_off got=%b exp=0000", s_rdy); end
        at_pos();
        checks++; if (m_vld !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", m_vld); end
    endtask

    task automatic test_fairness();
        logic [31:0] exp_cnt;
        pulse_reset();
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = 64'hC0DE_0000_0000_0000 | 64'(i);
        s_vld = 4'hF;
        m_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (s_rdy !== 4'(1 << (k % 4))) begin failures++; $display("FAIL fair_s_rdy k=%0d got=%b exp=%b", k, s_rdy, 4'(1 << (k % 4))); end
            at_pos();
            checks++; if (m_src !== 2'(k % 4) || m_vld !== 1'b1) begin failures++; $display("FAIL fair_m_src k=%0d got=%0d exp=%0d", k, m_src, k % 4); end
            checks++; if (m_data !== (64'hC0DE_0000_0000_0000 | 64'(k % 4))) begin failures++; $display("FAIL fair_m_data k=%0d got=%h", k, m_data); end
            @(negedge clk);
        end
`ifdef CPU_ARBITER_STATS_EN
        exp_cnt = 32'd8;
`else
        exp_cnt = 32'd0;
`endif
        checks++; if (xfer_count !== exp_cnt) begin failures++; $display("FAIL fair_xfer_count got=%0d exp=%0d", xfer_count, exp_cnt); end
        s_vld = 4'h0;
        at_pos();
        checks++; if (m_vld !== 1'b0) begin failures++; $display("FAIL fair_drain got=%b exp=0", m_vld); end
    endtask

    task automatic test_backpressure();
        // Pointer last granted CPU 3, so CPU 0 wins first.
        @(negedge clk);
        s_data[0*DW +: DW] = 64'hAAAA_0000_0000_0000;
        s_data[1*DW +: DW] = 64'hBBBB_1111_1111_1111;
        s_data[2*DW +: DW] = 64'hCCCC_2222_2222_2222;
        s_vld = 4'b0001;
        m_rdy = 1'b1;
        at_pos();
        @(negedge clk);
        s_vld = 4'b0110;
        m_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (s_rdy !== 4'b0000) begin failures++; $display("FAIL bp_s_rdy k=%0d got=%b exp=0000", k, s_rdy); end
            checks++; if (m_vld !== 1'b1 || m_src !== 2'd0 || m_data !== 64'hAAAA_0000_0000_0000) begin
                failures++; $display("FAIL bp_hold k=%0d vld=%b src=%0d data=%h exp src=0 data=aaaa000000000000", k, m_vld, m_src, m_data);
            end
            @(negedge clk);
        end
        m_rdy = 1'b1;
        #1;
        checks++; if (s_rdy !== 4'b0010) begin failures++; $display("FAIL bp_release_s_rdy got=%b exp=0010", s_rdy); end
        at_pos();
        checks++; if (m_vld !== 1'b1 || m_src !== 2'd1 || m_data !== 64'hBBBB_1111_1111_1111) begin
            failures++; $display("FAIL bp_next src=%0d data=%h exp src=1", m_src, m_data);
        end
        @(negedge clk);
        s_vld = 4'b0100;
        #1;
        checks++; if (s_rdy !== 4'b0100) begin failures++; $display("FAIL bp_third_s_rdy got=%b exp=0100", s_rdy); end
        at_pos();
        checks++; if (m_src !== 2'd2 || m_data !== 64'hCCCC_2222_2222_2222) begin failures++; $display("FAIL bp_third src=%0d data=%h exp src=2", m_src, m_data); end
        @(negedge clk);
        s_vld = 4'b0000;
        at_pos();
        checks++; if (m_vld !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", m_vld); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = 64'h5EED_0000_0000_0000 | 64'(i);
        s_vld = 4'b1000;
        m_rdy = 1'b0;
        at_pos();
        checks++; if (m_vld !== 1'b1 || m_src !== 2'd3) begin failures++; $display("FAIL rmid_full vld=%b src=%0d exp vld=1 src=3", m_vld, m_src); end
        @(negedge clk);
        s_vld = 4'hF;
        m_rdy = 1'b1;
        rst   = 1'b1;
        #1;
        checks++; if (s_rdy !== 4'h0) begin failures++; $display("FAIL rmid_s_rdy_in_rst got=%b exp=0", s_rdy); end
        at_pos();
        checks++; if (m_vld !== 1'b0) begin failures++; $display("FAIL rmid_m_vld got=%b exp=0", m_vld); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (s_rdy !== 4'b0001) begin failures++; $display("FAIL rmid_first_grant got=%b exp=0001", s_rdy); end
        at_pos();
        checks++; if (m_src !== 2'd0 || m_data !== 64'h5EED_0000_0000_0000) begin failures++; $display("FAIL rmid_src got=%0d data=%h exp src=0", m_src, m_data); end
        @(negedge clk);
        s_vld = 4'h0;
        at_pos();
    endtask

    task automatic test_completion();
        @(negedge clk);
        s_vld  = 4'h0;
        m_rdy  = 1'b1;
        s_done = 4'b0111;
        at_pos();
        checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL done_partial got=%b exp=0", all_done); end
        @(negedge clk);
        s_done = 4'hF;
        at_pos();
        checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL done_all got=%b exp=1", all_done); end
        // A CPU already done still gets served.
        @(negedge clk);
        s_data[1*DW +: DW] = 64'hD0E5_0000_0000_0001;
        s_vld = 4'b0010;
        m_rdy = 1'b0;
        #1;
        checks++; if (s_rdy !== 4'b0010) begin failures++; $display("FAIL done_serve_s_rdy got=%b exp=0010", s_rdy); end
        at_pos();
        checks++; if (all_done !== 1'b0 || m_vld !== 1'b1) begin failures++; $display("FAIL done_full all_done=%b m_vld=%b exp 0/1", all_done, m_vld); end
        @(negedge clk);
        s_vld = 4'h0;
        at_pos();
        checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL done_held got=%b exp=0", all_done); end
        @(negedge clk);
        m_rdy = 1'b1;
        at_pos();
        checks++; if (all_done !== 1'b1 || m_vld !== 1'b0) begin failures++; $display("FAIL done_after_drain all_done=%b m_vld=%b exp 1/0", all_done, m_vld); end
    endtask

    task automatic test_integration();
        int sent [N];
        int rcvd [N];
        int total;
        int cycles;
        logic [N-1:0] acc;
        pulse_reset();
        s_done = '0;
        for (int i = 0; i < N; i++) begin sent[i] = 0; rcvd[i] = 0; end
        total  = 0;
        cycles = 0;
        while (total < N * TRANSACTION_NB && cycles < 1000) begin
            m_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                s_vld[i]  = (sent[i] < TRANSACTION_NB);
                s_done[i] = (sent[i] >= TRANSACTION_NB);
                s_data[i*DW +: DW] = {8'(i), 24'h0, 32'(sent[i])};
            end
            #1;
            if ((s_rdy & ~s_vld) != 0 || !$onehot0(s_rdy)) begin
                checks++; failures++;
                $display("FAIL integ_s_rdy got=%b vld=%b", s_rdy, s_vld);
            end
            acc = s_rdy;
            if (m_vld && m_rdy) begin
                checks++;
                if (m_data[63:56] !== 8'(m_src) || m_data[31:0] !== 32'(rcvd[m_src])) begin
                    failures++;
                    $display("FAIL integ_order src=%0d got=%h exp_seq=%0d", m_src, m_data, rcvd[m_src]);
                end
                rcvd[m_src]++;
                total++;
            end
            @(posedge clk);
            for (int i = 0; i < N; i++) if (acc[i]) sent[i]++;
            @(negedge clk);
            cycles++;
        end
        checks++; if (total !== N * TRANSACTION_NB) begin failures++; $display("FAIL integ_total got=%0d exp=%0d", total, N * TRANSACTION_NB); end
        s_vld  = '0;
        s_done = 4'hF;
        m_rdy  = 1'b1;
        at_pos();
        @(negedge clk);
        at_pos();
        checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL integ_all_done got=%b exp=1", all_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_completion();
        test_integration();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cpu_arbiter

`default_nettype wire
